// File: rtl/rs232_sim_chan.sv
// RS232 channel model: FIFO-fed serializer on TX, sampling deserializer on RX.
// Frame format (data bits, parity, stop bits) and bit rate are set by parameters.
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | line high; TX pops FIFO / RX waits for a start edge
// S_START | start bit (TX drives low, RX re-checks at mid-bit)
// S_DATA  | data bits, LSB first
// S_PAR   | parity bit (unused when PARITY = 0)
// S_STOP  | stop bit(s); RX strobes its result at mid-bit
module rs232_sim_chan #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 16
) (
    input  logic                        CLK_50MHZ,
    input  logic                        RST,
    output logic                        TX,
    input  logic                        RX,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic                        tx_busy,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    output logic                        rx_frame_err,
    output logic                        rx_parity_err
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(TX_DEPTH);
    localparam int CW  = $clog2(STOP_BITS * DIV) + 1;
    localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(STOP_BITS * DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);
    localparam logic          HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DATA_BITS-1:0] fifo_mem [TX_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          fifo_cnt;
    logic                 push, pop;

    state_t               tx_state, tx_next;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_tc;

    assign tx_ready = (fifo_cnt != (AW+1)'(TX_DEPTH));
    assign tx_level = fifo_cnt;
    assign push     = tx_valid && tx_ready;
    assign pop      = (tx_state == S_IDLE) && (fifo_cnt != '0);

    always_ff @(posedge CLK_50MHZ) begin
        if (push && !RST)
            fifo_mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_cnt <= fifo_cnt + (AW+1)'(1);
            else if (pop && !push)
                fifo_cnt <= fifo_cnt - (AW+1)'(1);
        end
    end

    assign tx_tc = (tx_cnt == '0);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            S_IDLE:  if (pop) tx_next = S_START;
            S_START: if (tx_tc) tx_next = S_DATA;
            S_DATA:  if (tx_tc && tx_idx == LAST_BIT) tx_next = HAS_PAR ? S_PAR : S_STOP;
            S_PAR:   if (tx_tc) tx_next = S_STOP;
            S_STOP:  if (tx_tc) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (pop) begin
                tx_shift <= fifo_mem[rd_ptr];
                tx_par   <= (^fifo_mem[rd_ptr]) ^ PAR_ODD;
                tx_cnt   <= BIT_LOAD;
                tx_idx   <= '0;
            end else if (tx_state != S_IDLE) begin
                if (tx_tc) begin
                    tx_cnt <= (tx_next == S_STOP) ? STOP_LOAD : BIT_LOAD;
                    if (tx_state == S_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - CW'(1);
                end
            end
        end
    end

    always_comb begin
        TX = 1'b1;
        case (tx_state)
            S_START: TX = 1'b0;
            S_DATA:  TX = tx_shift[0];
            S_PAR:   TX = tx_par;
            default: TX = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state != S_IDLE);

    logic [1:0]           rx_sync;
    logic                 rx_s;
    state_t               rx_state, rx_next;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_perr;
    logic                 rx_armed;
    logic                 rx_tc;

    assign rx_s  = rx_sync[1];
    assign rx_tc = (rx_cnt == '0);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (!rx_s && rx_armed) rx_next = S_START;
            S_START: if (rx_tc) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tc && rx_idx == LAST_BIT) rx_next = HAS_PAR ? S_PAR : S_STOP;
            S_PAR:   if (rx_tc) rx_next = S_STOP;
            S_STOP:  if (rx_tc) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            rx_sync       <= 2'b11;
            rx_state      <= S_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_shift      <= '0;
            rx_perr       <= 1'b0;
            rx_armed      <= 1'b1;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], RX};
            rx_state <= rx_next;
            rx_valid <= 1'b0;
            if (rx_state == S_IDLE) begin
                rx_cnt  <= HALF_LOAD;
                rx_idx  <= '0;
                rx_perr <= 1'b0;
            end else if (rx_tc) begin
                rx_cnt <= BIT_LOAD;
            end else begin
                rx_cnt <= rx_cnt - CW'(1);
            end
            if (rx_state == S_DATA && rx_tc) begin
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                rx_idx   <= rx_idx + 3'd1;
            end
            if (rx_state == S_PAR && rx_tc)
                rx_perr <= (^rx_shift) ^ rx_s ^ PAR_ODD;
            if (rx_state == S_STOP && rx_tc) begin
                rx_valid      <= 1'b1;
                rx_data       <= rx_shift;
                rx_frame_err  <= !rx_s;
                rx_parity_err <= rx_perr;
            end
            // a low stop bit disarms start detection until the line is seen idle
            if (rx_state == S_STOP && rx_tc && !rx_s)
                rx_armed <= 1'b0;
            else if (rx_s)
                rx_armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rs232_sim_chan.sv
// Directed bench for rs232_sim_chan: 8N1 TX/RX unit, 8E2 loopback unit, 8O1 RX unit.
// DIV = 16 for all instances; inputs change and outputs are sampled on the falling edge.
module tb_rs232_sim_chan;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst     = 1'b1;
    logic rx_line = 1'b1;

    logic       tx_a, rdy_a, busy_a, rxv_a, fe_a, pe_a;
    logic [7:0] txd_a = 8'h00, rxd_a;
    logic       txv_a = 1'b0;
    logic [2:0] lvl_a;

    logic       tx_b, rdy_b, busy_b, rxv_b, fe_b, pe_b;
    logic [7:0] txd_b = 8'h00, rxd_b;
    logic       txv_b = 1'b0;
    logic [4:0] lvl_b;

    logic       tx_c, rdy_c, busy_c, rxv_c, fe_c, pe_c;
    logic [7:0] txd_c = 8'h00, rxd_c;
    logic       txv_c = 1'b0;
    logic [4:0] lvl_c;

    rs232_sim_chan #(.CLK_HZ(50000000), .BAUD(3125000), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .TX_DEPTH(4)) dut_a (
        .CLK_50MHZ(clk), .RST(rst), .TX(tx_a), .RX(rx_line),
        .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(rdy_a), .tx_level(lvl_a), .tx_busy(busy_a),
        .rx_data(rxd_a), .rx_valid(rxv_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a));

    rs232_sim_chan #(.CLK_HZ(50000000), .BAUD(3125000), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(2), .TX_DEPTH(16)) dut_b (
        .CLK_50MHZ(clk), .RST(rst), .TX(tx_b), .RX(tx_b),
        .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(rdy_b), .tx_level(lvl_b), .tx_busy(busy_b),
        .rx_data(rxd_b), .rx_valid(rxv_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b));

    rs232_sim_chan #(.CLK_HZ(50000000), .BAUD(3125000), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .TX_DEPTH(16)) dut_c (
        .CLK_50MHZ(clk), .RST(rst), .TX(tx_c), .RX(rx_line),
        .tx_data(txd_c), .tx_valid(txv_c), .tx_ready(rdy_c), .tx_level(lvl_c), .tx_busy(busy_c),
        .rx_data(rxd_c), .rx_valid(rxv_c), .rx_frame_err(fe_c), .rx_parity_err(pe_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // receive strobe monitors
    int         n_a = 0, n_b = 0, n_c = 0;
    logic [7:0] last_a = 8'h00, last_c = 8'h00;
    logic       lfe_a = 1'b0, lpe_a = 1'b0, lfe_c = 1'b0, lpe_c = 1'b0;
    logic [7:0] got_b [4];
    logic       errs_b = 1'b0;

    always @(negedge clk) begin
        if (rxv_a === 1'b1) begin
            n_a    <= n_a + 1;
            last_a <= rxd_a;
            lfe_a  <= fe_a;
            lpe_a  <= pe_a;
        end
        if (rxv_c === 1'b1) begin
            n_c    <= n_c + 1;
            last_c <= rxd_c;
            lfe_c  <= fe_c;
            lpe_c  <= pe_c;
        end
        if (rxv_b === 1'b1) begin
            n_b    <= n_b + 1;
            if (n_b < 4) got_b[n_b] <= rxd_b;
            errs_b <= errs_b | fe_b | pe_b;
        end
    end

    // 8N1 frame on dut_a TX; the first sample is the next falling edge
    task automatic tx_frame(input logic [7:0] d, output int errs);
        logic exp;
        errs = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (i < 16)       exp = 1'b0;
            else if (i < 144) exp = d[(i - 16) / 16];
            else              exp = 1'b1;
            if (tx_a !== exp || busy_a !== 1'b1) errs++;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par,
                              input logic stop);
        rx_line = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            repeat (16) @(negedge clk);
        end
        if (has_par) begin
            rx_line = par;
            repeat (16) @(negedge clk);
        end
        rx_line = stop;
        repeat (16) @(negedge clk);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [7:0] fifo_bytes [6];
    logic [7:0] lb_bytes [3];

    initial begin
        int errs, ferr, base_a, base_c;
        fifo_bytes[0] = 8'h11; fifo_bytes[1] = 8'h22; fifo_bytes[2] = 8'h33;
        fifo_bytes[3] = 8'h44; fifo_bytes[4] = 8'h55; fifo_bytes[5] = 8'h66;
        lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h3C;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_ready", rdy_a, 1);
        chk("rst_level", lvl_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_rx_data", rxd_a, 0);
        chk("rst_rx_valid", rxv_a, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        txd_a = 8'hA5; txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
        tx_frame(8'hA5, errs);
        chk("single_frame_bits", errs, 0);
        @(negedge clk);
        chk("single_busy_fall", busy_a, 0);
        chk("single_idle_high", tx_a, 1);
        repeat (4) @(negedge clk);

        ferr = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    txd_a = fifo_bytes[i]; txv_a = 1'b1;
                    @(negedge clk);
                    if (i == 3) begin
                        chk("fifo_ready_at3", rdy_a, 1);
                        chk("fifo_level_at3", lvl_a, 3);
                    end
                    if (i == 4) begin
                        chk("fifo_full_ready", rdy_a, 0);
                        chk("fifo_full_level", lvl_a, 4);
                    end
                end
                txv_a = 1'b0;
                chk("fifo_overflow_level", lvl_a, 4);
            end
            begin
                int e;
                @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    tx_frame(fifo_bytes[k], e);
                    ferr += e;
                    @(negedge clk);
                    if (tx_a !== 1'b1 || busy_a !== 1'b0) ferr++;
                end
            end
        join
        chk("fifo_stream", ferr, 0);
        chk("fifo_drained", lvl_a, 0);
        errs = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) errs++;
        end
        chk("fifo_no_extra_frame", errs, 0);
        chk("rx_quiet_a", n_a, 0);

        for (int i = 0; i < 3; i++) begin
            txd_b = lb_bytes[i]; txv_b = 1'b1;
            @(negedge clk);
        end
        txv_b = 1'b0;
        for (int i = 0; i < 2000 && n_b < 3; i++) @(negedge clk);
        repeat (40) @(negedge clk);
        chk("loop_count", n_b, 3);
        chk("loop_byte0", got_b[0], 8'h00);
        chk("loop_byte1", got_b[1], 8'hFF);
        chk("loop_byte2", got_b[2], 8'h3C);
        chk("loop_errs", errs_b, 0);

        base_a = n_a;
        send_frame(8'h3A, 1'b0, 1'b0, 1'b1);
        chk("rx_ok_count", n_a - base_a, 1);
        chk("rx_ok_data", last_a, 8'h3A);
        chk("rx_ok_ferr", lfe_a, 0);
        chk("rx_ok_perr", lpe_a, 0);

        base_a = n_a;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        chk("rx_ferr_count", n_a - base_a, 1);
        chk("rx_ferr_data", last_a, 8'h55);
        chk("rx_ferr_flag", lfe_a, 1);

        base_a = n_a;
        rx_line = 1'b0;
        repeat (400) @(negedge clk);
        rx_line = 1'b1;
        repeat (40) @(negedge clk);
        chk("break_count", n_a - base_a, 1);
        chk("break_ferr", lfe_a, 1);
        chk("break_data", last_a, 8'h00);

        base_a = n_a;
        send_frame(8'hC6, 1'b0, 1'b0, 1'b1);
        chk("rearm_count", n_a - base_a, 1);
        chk("rearm_data", last_a, 8'hC6);
        chk("rearm_ferr", lfe_a, 0);

        base_c = n_c;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        chk("odd_ok_count", n_c - base_c, 1);
        chk("odd_ok_data", last_c, 8'hA5);
        chk("odd_ok_perr", lpe_c, 0);
        chk("odd_ok_ferr", lfe_c, 0);
        base_c = n_c;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        chk("odd_bad_count", n_c - base_c, 1);
        chk("odd_bad_perr", lpe_c, 1);
        chk("odd_bad_ferr", lfe_c, 0);

        base_a = n_a; base_c = n_c;
        rx_line = 1'b0;
        repeat (4) @(negedge clk);
        rx_line = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_a", n_a - base_a, 0);
        chk("glitch_c", n_c - base_c, 0);

        txd_a = 8'h5A; txv_a = 1'b1;
        @(negedge clk);
        txd_a = 8'h0F;
        @(negedge clk);
        txv_a = 1'b0;
        repeat (52) @(negedge clk);
        chk("mid_bit2", tx_a, 0);
        chk("mid_level", lvl_a, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", tx_a, 1);
        chk("mid_rst_level", lvl_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        txd_a = 8'hC3; txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
        tx_frame(8'hC3, errs);
        chk("post_rst_frame", errs, 0);
        @(negedge clk);
        chk("post_rst_busy", busy_a, 0);
        chk("post_rst_level", lvl_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
